calc_port_responder: RTL and testbench

CALC_PORT_RESPONDER -- requirements
Module: calc_port_responder

---
 rtl/calc_pkg.sv | 40 ++++
 rtl/calc_alu.sv | 55 +++++
 rtl/calc_port_responder.sv | 155 +++++++++++++++
 tb/tb_calc_port_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculation port responder.
// Holds command/response encodings, the capture FSM state type, data widths,
// and the expected-response record used by the verification environment.
package calc_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned RESP_W = 2;

    // Command encodings; every other non-zero value is an invalid command.
    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } calc_cmd_e;

    // Response encodings; 2'd3 is never driven.
    typedef enum logic [RESP_W-1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } calc_resp_e;

    // Command capture FSM.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OP2  = 1'b1
    } calc_state_e;

    // Expected response record for the testbench scoreboard.
    typedef struct packed {
        logic [RESP_W-1:0] resp;
        logic [DATA_W-1:0] data;
        logic [7:0]        tag;
        logic [31:0]       due;
    } calc_exp_t;

endpackage

// File: rtl/calc_alu.sv
// Combinational arithmetic unit for the calculation port responder.
// Ports:
//   cmd  - captured command
//   op1  - operand 1
//   op2  - operand 2 (only op2[4:0] matters for shifts)
//   resp - success / error code
//   data - result, forced to 0 on any error
module calc_alu
    import calc_pkg::*;
(
    input  logic [CMD_W-1:0]  cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [RESP_W-1:0] resp,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W:0] sum;

    // Extra bit exposes the carry out of bit 31.
    assign sum = {1'b0, op1} + {1'b0, op2};

    // Result select; anything not matched is reported as an error.
    always_comb begin
        resp = RESP_ERR;
        data = '0;
        case (calc_cmd_e'(cmd))
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    resp = RESP_OK;
                    data = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (op2 <= op1) begin
                    resp = RESP_OK;
                    data = op1 - op2;
                end
            end
            CMD_SHL: begin
                resp = RESP_OK;
                data = op1 << op2[4:0];
            end
            CMD_SHR: begin
                resp = RESP_OK;
                data = op1 >> op2[4:0];
            end
            default: begin
                resp = RESP_ERR;
                data = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc_port_responder.sv
// Two-cycle command port with a fixed-latency response pipeline.
// A command cycle carries cmd/op1/tag, the following cycle carries op2; the
// result appears LATENCY cycles after the op2 cycle for exactly one cycle.
// Ports:
//   c_clk       - clock
//   reset       - asynchronous active-low reset
//   req_cmd_in  - command (0 = nop)
//   req_data_in - op1 in the command cycle, op2 in the following cycle
//   req_tag_in  - tag, sampled in the command cycle
//   out_resp    - 0 none, 1 success, 2 error (registered)
//   out_data    - result (registered, 0 when no response)
//   out_tag     - tag being answered (registered, 0 when no response)
//   proto_err   - same-cycle pulse on a protocol violation
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned TAG_W   = 2
)
(
    input  logic              c_clk,
    input  logic              reset,
    input  logic [CMD_W-1:0]  req_cmd_in,
    input  logic [DATA_W-1:0] req_data_in,
    input  logic [TAG_W-1:0]  req_tag_in,
    output logic [RESP_W-1:0] out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              proto_err
);

    localparam int unsigned NUM_TAGS = 1 << TAG_W;

    calc_state_e         state_q;
    calc_state_e         state_d;
    logic [CMD_W-1:0]    cmd_q;
    logic [DATA_W-1:0]   op1_q;
    logic [TAG_W-1:0]    tag_q;
    logic [NUM_TAGS-1:0] outst_q;
    logic [NUM_TAGS-1:0] outst_d;

    logic [RESP_W-1:0]   pipe_resp [LATENCY];
    logic [DATA_W-1:0]   pipe_data [LATENCY];
    logic [TAG_W-1:0]    pipe_tag  [LATENCY];

    logic                accept;
    logic                issue;
    logic                resp_fire;
    logic                tag_busy;
    logic [RESP_W-1:0]   alu_resp;
    logic [DATA_W-1:0]   alu_data;

    // A response leaving this cycle frees its tag for immediate re-issue.
    assign resp_fire = (out_resp != RESP_NONE);
    assign tag_busy  = outst_q[req_tag_in] && !(resp_fire && (out_tag == req_tag_in));
    assign issue     = (state_q == ST_OP2);

    // Capture FSM state register.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture FSM next state, command acceptance and violation detection.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        proto_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_cmd_in != CMD_W'(CMD_NOP)) begin
                    if (tag_busy) begin
                        proto_err = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_OP2;
                    end
                end
            end
            ST_OP2: begin
                state_d   = ST_IDLE;
                proto_err = (req_cmd_in != CMD_W'(CMD_NOP));
            end
        endcase
    end

    // Command, operand 1 and tag capture.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            cmd_q <= '0;
            op1_q <= '0;
            tag_q <= '0;
        end else if (accept) begin
            cmd_q <= req_cmd_in;
            op1_q <= req_data_in;
            tag_q <= req_tag_in;
        end
    end

    // Outstanding-tag scoreboard; a set on re-issue wins over the clear.
    always_comb begin
        outst_d = outst_q;
        if (resp_fire) begin
            outst_d[out_tag] = 1'b0;
        end
        if (accept) begin
            outst_d[req_tag_in] = 1'b1;
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            outst_q <= '0;
        end else begin
            outst_q <= outst_d;
        end
    end

    // Operand 2 is taken straight from the port in the OP2 cycle.
    calc_alu u_alu (
        .cmd  (cmd_q),
        .op1  (op1_q),
        .op2  (req_data_in),
        .resp (alu_resp),
        .data (alu_data)
    );

    // Delay line; empty slots carry all-zero so the last stage drives the outputs.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_resp[i] <= '0;
                pipe_data[i] <= '0;
                pipe_tag[i]  <= '0;
            end
        end else begin
            pipe_resp[0] <= issue ? alu_resp : '0;
            pipe_data[0] <= issue ? alu_data : '0;
            pipe_tag[0]  <= issue ? tag_q    : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_resp[i] <= pipe_resp[i-1];
                pipe_data[i] <= pipe_data[i-1];
                pipe_tag[i]  <= pipe_tag[i-1];
            end
        end
    end

    assign out_resp = pipe_resp[LATENCY-1];
    assign out_data = pipe_data[LATENCY-1];
    assign out_tag  = pipe_tag[LATENCY-1];

endmodule

// File: tb/tb_calc_port_responder.sv
// Scoreboard testbench for calc_port_responder: directed cases plus random
// traffic, checked against a behavioural model of the command port.
module tb_calc_port_responder;
    import calc_pkg::*;

    localparam int unsigned LAT   = 3;
    localparam int unsigned TAG_W = 2;
    localparam int unsigned NTAG  = 1 << TAG_W;

    logic              c_clk;
    logic              reset;
    logic [3:0]        req_cmd_in;
    logic [31:0]       req_data_in;
    logic [TAG_W-1:0]  req_tag_in;
    logic [1:0]        out_resp;
    logic [31:0]       out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              proto_err;

    calc_port_responder #(.LATENCY(LAT), .TAG_W(TAG_W)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .proto_err   (proto_err)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    always @(posedge c_clk) cyc <= cyc + 1;

    // Behavioural model state.
    calc_exp_t    exp_q[$];
    logic         exp_proto = 1'b0;
    bit           m_op2 = 1'b0;
    logic [3:0]   m_cmd;
    logic [31:0]  m_op1;
    logic [TAG_W-1:0] m_tag;
    bit           os [NTAG];
    int unsigned  due [NTAG];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference arithmetic from the command definitions.
    task automatic ref_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                            output logic [1:0] r, output logic [31:0] d);
        longint unsigned s;
        r = 2'd2;
        d = 32'd0;
        case (c)
            4'd1: begin
                s = longint'(a) + longint'(b);
                if (s <= 64'h0000_0000_FFFF_FFFF) begin r = 2'd1; d = s[31:0]; end
            end
            4'd2: if (b <= a) begin r = 2'd1; d = a - b; end
            4'd5: begin s = {32'd0, a} << b[4:0]; r = 2'd1; d = s[31:0]; end
            4'd6: begin s = {32'd0, a} >> b[4:0]; r = 2'd1; d = s[31:0]; end
            default: begin r = 2'd2; d = 32'd0; end
        endcase
    endtask

    // Decide what the port does with this cycle's inputs.
    task automatic model_cycle();
        logic [1:0]  r;
        logic [31:0] d;
        calc_exp_t   e;
        exp_proto = 1'b0;
        if (m_op2) begin
            exp_proto = (req_cmd_in != 4'd0);
            ref_calc(m_cmd, m_op1, req_data_in, r, d);
            e.resp = r;
            e.data = d;
            e.tag  = 8'(m_tag);
            e.due  = cyc + LAT;
            exp_q.push_back(e);
            due[m_tag] = cyc + LAT;
            m_op2 = 1'b0;
        end else if (req_cmd_in != 4'd0) begin
            if (os[req_tag_in] && due[req_tag_in] > cyc) begin
                exp_proto = 1'b1;
            end else begin
                os[req_tag_in]  = 1'b1;
                due[req_tag_in] = 32'hFFFF_FFFF;
                m_op2 = 1'b1;
                m_cmd = req_cmd_in;
                m_op1 = req_data_in;
                m_tag = req_tag_in;
            end
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] d, input logic [TAG_W-1:0] t);
        req_cmd_in  = c;
        req_data_in = d;
        req_tag_in  = t;
        model_cycle();
        @(posedge c_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(4'd0, $urandom, TAG_W'($urandom));
    endtask

    task automatic do_reset(input int n);
        reset       = 1'b0;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        req_tag_in  = '0;
        exp_proto   = 1'b0;
        exp_q.delete();
        m_op2 = 1'b0;
        for (int i = 0; i < NTAG; i++) begin os[i] = 1'b0; due[i] = 0; end
        repeat (n) @(posedge c_clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: compares every cycle against the model, away from the clock edge.
    always @(negedge c_clk) begin
        calc_exp_t e;
        if (!reset) begin
            check("reset_outputs", {out_resp, out_data, 6'(out_tag), proto_err}, 64'd0);
        end else begin
            check("proto_err", 64'(proto_err), 64'(exp_proto));
            if (out_resp != 2'd0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp at cycle %0d: got resp %0d data 0x%0h tag %0d, required none",
                             cyc, out_resp, out_data, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("resp", 64'(out_resp), 64'(e.resp));
                    check("data", 64'(out_data), 64'(e.data));
                    check("tag",  64'(out_tag),  64'(e.tag));
                    check("latency_cycle", 64'(cyc), 64'(e.due));
                end
            end else begin
                check("idle_outputs", {out_data, 32'(out_tag)}, 64'd0);
                if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_resp at cycle %0d: got none, required resp %0d data 0x%0h tag %0d",
                             cyc, e.resp, e.data, e.tag);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  c;
        logic [31:0] d;
        int unsigned r;
        reset       = 1'b0;
        req_cmd_in  = 4'd0;
        req_data_in = 32'd0;
        req_tag_in  = '0;
        do_reset(3);

        // Accept right after reset release; 5 + 7.
        drive(CMD_ADD, 32'h0000_0005, 2'd1);
        drive(CMD_NOP, 32'h0000_0007, 2'd1);
        idle(5);

        // Add overflow and sub underflow.
        drive(CMD_ADD, 32'hFFFF_FFFF, 2'd2);
        drive(CMD_NOP, 32'h0000_0001, 2'd0);
        drive(CMD_SUB, 32'd3, 2'd3);
        drive(CMD_NOP, 32'd4, 2'd0);
        idle(5);

        // Shift uses only op2[4:0]; invalid command answers with error.
        drive(CMD_SHL, 32'h1, 2'd0);
        drive(CMD_NOP, 32'h0000_0024, 2'd0);
        drive(4'd9, 32'h1234_5678, 2'd3);
        drive(CMD_NOP, 32'h1, 2'd0);
        drive(CMD_SHR, 32'h8000_0000, 2'd2);
        drive(CMD_NOP, 32'hFFFF_FFE3, 2'd0);
        idle(5);

        // Back-to-back commands on all four tags.
        drive(CMD_ADD, 32'd100, 2'd0); drive(CMD_NOP, 32'd23, 2'd0);
        drive(CMD_SUB, 32'd100, 2'd1); drive(CMD_NOP, 32'd23, 2'd0);
        drive(CMD_SHL, 32'h3,   2'd2); drive(CMD_NOP, 32'd8,  2'd0);
        drive(CMD_SHR, 32'hF00, 2'd3); drive(CMD_NOP, 32'd4,  2'd0);
        idle(5);

        // Busy tag re-issued, then legally re-issued in its response cycle.
        drive(CMD_ADD, 32'd10, 2'd1);
        drive(CMD_NOP, 32'd20, 2'd0);
        drive(CMD_ADD, 32'd30, 2'd1);
        drive(CMD_NOP, 32'd40, 2'd1);
        drive(CMD_SUB, 32'd50, 2'd1);
        drive(CMD_NOP, 32'd8,  2'd0);
        idle(5);

        // Command in the operand-2 cycle is a violation, not executed.
        drive(CMD_ADD, 32'd1, 2'd3);
        drive(CMD_SHR, 32'd2, 2'd0);
        idle(5);

        // Reset one cycle after the operand-2 cycle drops the command.
        drive(CMD_ADD, 32'd1, 2'd2);
        drive(CMD_NOP, 32'd2, 2'd0);
        do_reset(2);
        idle(LAT + 5);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: c = 4'd0;
                3:       c = 4'd1;
                4:       c = 4'd2;
                5:       c = 4'd5;
                6:       c = 4'd6;
                7:       c = 4'd1;
                8:       c = 4'd2;
                default: begin
                    c = 4'($urandom_range(7, 15));
                    if ($urandom_range(0, 1) == 0) c = 4'($urandom_range(3, 4));
                end
            endcase
            d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 40));
            if ($urandom_range(0, 7) == 0) d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            drive(c, d, TAG_W'($urandom));
        end
        idle(LAT + 3);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
